// File: rtl/memory_access_sequencer.sv
// Data-memory access engine: word/sub-word loads and stores against a word-addressed
// single-port RAM without byte enables; sub-word stores run as read-modify-write.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready high, waiting for a request
// READ    | RAM read in flight, held MEM_LATENCY cycles by lat_cnt
// WRITE   | mem_we high for one cycle (word store or RMW write-back)
// RESP    | one-cycle resp_valid pulse, then back to IDLE
module memory_access_sequencer #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_WORDS   = 8192,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [1:0]            req_offset,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_fault,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);
   localparam logic [2:0]          LAT_LOAD   = 3'(MEM_LATENCY - 1);

   state_t                state_q, state_d;
   logic [2:0]            lat_cnt_q, lat_cnt_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  mem_we_q, mem_we_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_fault_q, resp_fault_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  write_q, write_d;
   logic [1:0]            offset_q, offset_d;
   logic [1:0]            size_q, size_d;
   logic                  signed_q, signed_d;
   logic [15:0]           sub_wdata_q, sub_wdata_d;

   logic                  req_fault;
   logic [4:0]            lane_shift;
   logic [7:0]            byte_lane;
   logic [15:0]           half_lane;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merge_data;

   always_comb begin
      req_fault = ({1'b0, req_address} >= ADDR_LIMIT)
               || (req_size == 2'd3)
               || ((req_size == 2'd0) && (req_offset != 2'd0))
               || ((req_size == 2'd1) && req_offset[0]);
   end

   // Lane extraction and merge both act on the word returned by the RAM this cycle.
   always_comb begin
      lane_shift = {offset_q, 3'b000};
      byte_lane  = 8'(mem_rdata >> lane_shift);
      half_lane  = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'd1:    load_data = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0000, half_lane};
         2'd2:    load_data = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h000000, byte_lane};
         default: load_data = mem_rdata;
      endcase
      if (size_q == 2'd1) begin
         merge_data = offset_q[1] ? {sub_wdata_q, mem_rdata[15:0]} : {mem_rdata[31:16], sub_wdata_q};
      end else begin
         merge_data = (mem_rdata & ~(DATA_WIDTH'(8'hFF) << lane_shift))
                    | (DATA_WIDTH'(sub_wdata_q[7:0]) << lane_shift);
      end
   end

   always_comb begin
      state_d       = state_q;
      lat_cnt_d     = lat_cnt_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      resp_rdata_d  = '0;
      resp_fault_d  = 1'b0;
      write_d       = write_q;
      offset_d      = offset_q;
      size_d        = size_q;
      signed_d      = signed_q;
      sub_wdata_d   = sub_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d       = req_write;
               offset_d      = req_offset;
               size_d        = req_size;
               signed_d      = req_signed;
               sub_wdata_d   = req_wdata[15:0];
               mem_address_d = req_address;
               if (req_fault) begin
                  state_d      = ST_RESP;
                  resp_fault_d = 1'b1;
               end else if (req_write && (req_size == 2'd0)) begin
                  state_d     = ST_WRITE;
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d   = ST_READ;
                  lat_cnt_d = LAT_LOAD;
               end
            end
         end
         ST_READ: begin
            if (lat_cnt_q == 3'd0) begin
               if (write_q) begin
                  state_d     = ST_WRITE;
                  mem_wdata_d = merge_data;
               end else begin
                  state_d      = ST_RESP;
                  resp_rdata_d = load_data;
               end
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         ST_WRITE: state_d = ST_RESP;
         default:  state_d = ST_IDLE;
      endcase
      // Strobes follow the next state so they line up exactly with WRITE/RESP.
      mem_we_d     = (state_d == ST_WRITE);
      resp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         lat_cnt_q     <= '0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_we_q      <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_fault_q  <= 1'b0;
         resp_rdata_q  <= '0;
         write_q       <= 1'b0;
         offset_q      <= '0;
         size_q        <= '0;
         signed_q      <= 1'b0;
         sub_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         lat_cnt_q     <= lat_cnt_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
         resp_valid_q  <= resp_valid_d;
         resp_fault_q  <= resp_fault_d;
         resp_rdata_q  <= resp_rdata_d;
         write_q       <= write_d;
         offset_q      <= offset_d;
         size_q        <= size_d;
         signed_q      <= signed_d;
         sub_wdata_q   <= sub_wdata_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_fault  = resp_fault_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer: two instances (read latency 1 and 3), each with its
// own RAM, checked every cycle against a transaction-level model plus literal expectations.
module tb_memory_access_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;

   logic [1:0]  req_valid, req_ready, req_write, req_signed;
   logic [1:0]  resp_valid, resp_fault, mem_we;
   logic [31:0] req_address [2];
   logic [1:0]  req_offset [2];
   logic [1:0]  req_size [2];
   logic [31:0] req_wdata [2];
   logic [31:0] resp_rdata [2];
   logic [31:0] mem_address [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];

   logic [31:0] ram [2][8192];
   logic [31:0] shadow [2][8192];
   logic [31:0] hist_a, hist_b;

   int          acc_k [2];
   int          resp_k [2];
   int          we_k [2];
   int          n_acc [2];
   int          n_we [2];
   int          n_resp [2];
   logic [31:0] exp_addr [2];
   logic [31:0] exp_rdata [2];
   logic [31:0] exp_wdata [2];
   logic [1:0]  exp_fault;
   logic [12:0] we_addr [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   memory_access_sequencer #(.MEM_LATENCY(1)) u_dut0 (
      .clock(clk), .reset(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_address(req_address[0]), .req_offset(req_offset[0]), .req_size(req_size[0]),
      .req_signed(req_signed[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
      .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
      .mem_rdata(mem_rdata[0]));

   memory_access_sequencer #(.MEM_LATENCY(3)) u_dut1 (
      .clock(clk), .reset(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_address(req_address[1]), .req_offset(req_offset[1]), .req_size(req_size[1]),
      .req_signed(req_signed[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
      .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
      .mem_rdata(mem_rdata[1]));

   // Latency-1 RAM returns the presented address's word within the cycle; latency-3 RAM
   // returns the word for the address presented two cycles earlier.
   assign mem_rdata[0] = ram[0][mem_address[0][12:0]];
   assign mem_rdata[1] = ram[1][hist_b[12:0]];

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   function automatic logic f_fault(input logic [31:0] a, input int off, input int size);
      return (a >= 32'd8192) || (size == 3) || (size == 0 && off != 0) || (size == 1 && off % 2 == 1);
   endfunction

   function automatic logic [31:0] f_load(input logic [31:0] w, input int off, input int size,
                                          input logic sg);
      longint v;
      if (size == 2) begin
         v = longint'((w >> (8 * off)) & 32'hFF);
         if (sg && v >= 128) v = v - 256;
      end else if (size == 1) begin
         v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
         if (sg && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(w);
      end
      return v[31:0];
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [31:0] d,
                                           input int off, input int size);
      longint unit;
      longint m;
      unit = (size == 2) ? 256 : 65536;
      m    = (size == 2) ? (longint'(1) << (8 * off)) : (longint'(1) << (16 * (off / 2)));
      return 32'((longint'(w) - ((longint'(w) / m) % unit) * m) + (longint'(d) % unit) * m);
   endfunction

   task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL dut%0d %s: got %h expected %h (cycle %0d)", g, nm, act, exp, cyc);
      end
   endtask

   // Transaction model and environment RAMs, advanced on each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int g = 0; g < 2; g++) begin
            acc_k[g]    <= -100;
            resp_k[g]   <= -100;
            we_k[g]     <= -100;
            exp_addr[g] <= 32'h0;
         end
      end else begin
         hist_a <= mem_address[1];
         hist_b <= hist_a;
         for (int g = 0; g < 2; g++) begin
            if (mem_we[g]) begin
               ram[g][mem_address[g][12:0]] <= mem_wdata[g];
               n_we[g] <= n_we[g] + 1;
            end
            if (resp_valid[g]) n_resp[g] <= n_resp[g] + 1;
            if (cyc == we_k[g]) shadow[g][we_addr[g]] <= exp_wdata[g];
            if (req_valid[g] && cyc > resp_k[g]) begin
               acc_k[g]     <= cyc;
               n_acc[g]     <= n_acc[g] + 1;
               exp_addr[g]  <= req_address[g];
               we_addr[g]   <= req_address[g][12:0];
               exp_rdata[g] <= 32'h0;
               exp_fault[g] <= 1'b0;
               if (f_fault(req_address[g], int'(req_offset[g]), int'(req_size[g]))) begin
                  resp_k[g]    <= cyc + 1;
                  exp_fault[g] <= 1'b1;
               end else if (req_write[g] && req_size[g] == 2'd0) begin
                  we_k[g]      <= cyc + 1;
                  resp_k[g]    <= cyc + 2;
                  exp_wdata[g] <= req_wdata[g];
               end else if (!req_write[g]) begin
                  resp_k[g]    <= cyc + lat_of(g) + 1;
                  exp_rdata[g] <= f_load(shadow[g][req_address[g][12:0]], int'(req_offset[g]),
                                         int'(req_size[g]), req_signed[g]);
               end else begin
                  we_k[g]      <= cyc + lat_of(g) + 1;
                  resp_k[g]    <= cyc + lat_of(g) + 2;
                  exp_wdata[g] <= f_merge(shadow[g][req_address[g][12:0]], req_wdata[g],
                                          int'(req_offset[g]), int'(req_size[g]));
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         chk(g, "req_ready", 32'(req_ready[g]), 32'(!(cyc > acc_k[g] && cyc <= resp_k[g])));
         chk(g, "resp_valid", 32'(resp_valid[g]), 32'(cyc == resp_k[g]));
         chk(g, "mem_we", 32'(mem_we[g]), 32'(cyc == we_k[g]));
         chk(g, "mem_address", mem_address[g], exp_addr[g]);
         if (cyc == resp_k[g]) begin
            chk(g, "resp_rdata", resp_rdata[g], exp_rdata[g]);
            chk(g, "resp_fault", 32'(resp_fault[g]), 32'(exp_fault[g]));
         end
         if (cyc == we_k[g]) chk(g, "mem_wdata", mem_wdata[g], exp_wdata[g]);
      end
   end

   task automatic run(input int g, input logic w, input logic [31:0] a, input logic [1:0] off,
                      input logic [1:0] size, input logic sg, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat);
      int start;
      int i;
      @(negedge clk);
      req_write[g]   = w;
      req_address[g] = a;
      req_offset[g]  = off;
      req_size[g]    = size;
      req_signed[g]  = sg;
      req_wdata[g]   = wd;
      req_valid[g]   = 1'b1;
      start = n_acc[g];
      i = 0;
      while (n_acc[g] == start && i < 20) begin
         @(negedge clk);
         i++;
      end
      req_valid[g] = 1'b0;
      rd  = 32'hX;
      flt = 1'bX;
      lat = -1;
      if (n_acc[g] == start) begin
         chk(g, "accept timeout", 32'(n_acc[g]), 32'(start + 1));
         return;
      end
      i = 0;
      while (!resp_valid[g] && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (!resp_valid[g]) begin
         chk(g, "resp timeout", 32'(resp_valid[g]), 32'd1);
         return;
      end
      rd  = resp_rdata[g];
      flt = resp_fault[g];
      lat = cyc - acc_k[g];
   endtask

   logic [31:0] ld_exp [4] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF};
   logic [1:0]  ld_off [4] = '{2'd1, 2'd3, 2'd2, 2'd2};
   logic [1:0]  ld_sz  [4] = '{2'd2, 2'd2, 2'd1, 2'd1};
   logic        ld_sg  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   logic [31:0] ft_adr [5] = '{32'd8192, 32'h10, 32'h10, 32'h10, 32'hFFFFFFFF};
   logic [1:0]  ft_off [5] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd0};
   logic [1:0]  ft_sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
   logic        ft_wr  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [31:0] rd;
      logic        flt;
      int          lat;
      int          snap;
      int          k1;
      int          i;
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b0;  req_write[g] = 1'b0;  req_signed[g] = 1'b0;
         req_address[g] = '0;  req_offset[g] = '0;   req_size[g] = '0;  req_wdata[g] = '0;
         n_acc[g] = 0;  n_we[g] = 0;  n_resp[g] = 0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk(g, "reset req_ready", 32'(req_ready[g]), 32'd1);
         chk(g, "reset resp_valid", 32'(resp_valid[g]), 32'd0);
         chk(g, "reset mem_we", 32'(mem_we[g]), 32'd0);
         chk(g, "reset mem_address", mem_address[g], 32'h0);
         chk(g, "reset resp_rdata", resp_rdata[g], 32'h0);
      end
      rst_n = 1'b1;

      for (int g = 0; g < 2; g++) begin
         run(g, 1'b1, 32'h17FF, 2'd0, 2'd0, 1'b0, 32'hDEADBEEF, rd, flt, lat);
         chk(g, "word store latency", 32'(lat), 32'd2);
         run(g, 1'b0, 32'h17FF, 2'd0, 2'd0, 1'b0, 32'h0, rd, flt, lat);
         chk(g, "word load data", rd, 32'hDEADBEEF);
         chk(g, "word load latency", 32'(lat), 32'(lat_of(g) + 1));

         run(g, 1'b1, 32'h100, 2'd0, 2'd0, 1'b0, 32'h11223344, rd, flt, lat);
         snap = n_we[g];
         run(g, 1'b1, 32'h100, 2'd2, 2'd2, 1'b0, 32'h000000AB, rd, flt, lat);
         chk(g, "byte rmw latency", 32'(lat), 32'(lat_of(g) + 2));
         chk(g, "byte rmw ram", ram[g][13'h100], 32'h11AB3344);
         chk(g, "byte rmw write count", 32'(n_we[g] - snap), 32'd1);

         run(g, 1'b1, 32'h40, 2'd0, 2'd0, 1'b0, 32'h80FF7F01, rd, flt, lat);
         for (int j = 0; j < 4; j++) begin
            run(g, 1'b0, 32'h40, ld_off[j], ld_sz[j], ld_sg[j], 32'h0, rd, flt, lat);
            chk(g, "sub-word load", rd, ld_exp[j]);
         end

         snap = n_we[g];
         for (int j = 0; j < 5; j++) begin
            run(g, ft_wr[j], ft_adr[j], ft_off[j], ft_sz[j], 1'b0, 32'hFFFFFFFF, rd, flt, lat);
            chk(g, "fault flag", 32'(flt), 32'd1);
            chk(g, "fault rdata", rd, 32'h0);
            chk(g, "fault latency", 32'(lat), 32'd1);
         end
         chk(g, "fault no write", 32'(n_we[g] - snap), 32'd0);

         run(g, 1'b0, 32'h1FFF, 2'd0, 2'd0, 1'b0, 32'h0, rd, flt, lat);
         chk(g, "last word legal", 32'(flt), 32'd0);

         run(g, 1'b1, 32'h101, 2'd0, 2'd0, 1'b0, 32'hAAAABBBB, rd, flt, lat);
         run(g, 1'b1, 32'h101, 2'd2, 2'd1, 1'b0, 32'h00001234, rd, flt, lat);
         chk(g, "half rmw ram", ram[g][13'h101], 32'h1234BBBB);
      end

      // Latency-3 instance with req_valid held high across two back-to-back requests.
      @(negedge clk);
      req_write[1] = 1'b0;  req_address[1] = 32'h17FF;  req_offset[1] = 2'd0;
      req_size[1] = 2'd0;   req_signed[1] = 1'b0;       req_valid[1] = 1'b1;
      snap = n_acc[1];
      i = 0;
      while (n_acc[1] == snap && i < 20) begin @(negedge clk); i++; end
      k1 = acc_k[1];
      req_address[1] = 32'h40;
      i = 0;
      while (n_acc[1] < snap + 2 && i < 20) begin @(negedge clk); i++; end
      req_valid[1] = 1'b0;
      chk(1, "held valid second accept", 32'(acc_k[1] - k1), 32'd5);
      i = 0;
      while (!resp_valid[1] && i < 20) begin @(negedge clk); i++; end
      chk(1, "held valid second data", resp_rdata[1], 32'h80FF7F01);

      // Reset during the write-back cycle of a byte RMW on the latency-1 instance.
      run(0, 1'b1, 32'h200, 2'd0, 2'd0, 1'b0, 32'h55667788, rd, flt, lat);
      @(negedge clk);
      req_write[0] = 1'b1;  req_address[0] = 32'h200;  req_offset[0] = 2'd0;
      req_size[0] = 2'd2;   req_wdata[0] = 32'h99;     req_valid[0] = 1'b1;
      snap = n_acc[0];
      i = 0;
      while (n_acc[0] == snap && i < 20) begin @(negedge clk); i++; end
      req_valid[0] = 1'b0;
      i = 0;
      while (cyc != we_k[0] && i < 20) begin @(negedge clk); i++; end
      chk(0, "rmw write before reset", 32'(mem_we[0]), 32'd1);
      snap = n_resp[0];
      #2 rst_n = 1'b0;
      #1;
      chk(0, "async reset mem_we", 32'(mem_we[0]), 32'd0);
      chk(0, "async reset resp_valid", 32'(resp_valid[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk(0, "reset ram unchanged", ram[0][13'h200], 32'h55667788);
      chk(0, "reset no response", 32'(n_resp[0] - snap), 32'd0);
      chk(0, "ready after reset", 32'(req_ready[0]), 32'd1);
      run(0, 1'b0, 32'h200, 2'd0, 2'd0, 1'b0, 32'h0, rd, flt, lat);
      chk(0, "load after reset", rd, 32'h55667788);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
